// File: rtl/sync_pkg.sv
// Shared constants and helpers for the input synchroniser/filter blocks.
package sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;

  function automatic int filt_cnt_w(input int filt_len);
    return (filt_len <= 1) ? 1 : $clog2(filt_len);
  endfunction

  function automatic bit params_ok(
    input int sync_size,
    input int filt_len
  );
    return (sync_size >= SYNC_MIN_STAGES) && (filt_len >= 1);
  endfunction

endpackage

// File: rtl/sync_filt_ch.sv
// One channel: flop synchroniser, stability filter and edge pulses.
module sync_filt_ch
  import sync_pkg::*;
#(
  parameter int   SYNC_SIZE = 2,
  parameter int   FILT_LEN  = 4,
  parameter logic RST_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sig_out,
  output logic rise,
  output logic fall
);

  localparam int CW = filt_cnt_w(FILT_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

  if (!params_ok(SYNC_SIZE, FILT_LEN)) begin : g_bad_param
    $error("sync_filt_ch: need SYNC_SIZE >= %0d, FILT_LEN >= 1",
           SYNC_MIN_STAGES);
  end

  // Pure flop chain; only sync_q[0] may go metastable.
  (* ASYNC_REG = "TRUE" *)
  logic [SYNC_SIZE-1:0] sync_q;

  logic          d;
  logic          q;
  logic          upd;
  logic [CW-1:0] cnt;

  assign d       = sync_q[SYNC_SIZE-1];
  assign upd     = (d != q) && (cnt == CNT_MAX);
  assign sig_out = q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_SIZE{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_SIZE-2:0], sig_in};
    end
  end

  // Any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= RST_VAL;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= upd & d;
      fall <= upd & ~d;
      if (d == q) begin
        cnt <= '0;
      end else if (upd) begin
        q   <= d;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_sync_filt.sv
// Multi-channel async input conditioner: sync, deglitch, edge pulses.
module multi_sync_filt #(
  parameter int                  CHANNELS  = 4,
  parameter int                  SYNC_SIZE = 2,
  parameter int                  FILT_LEN  = 4,
  parameter logic [CHANNELS-1:0] RST_VAL   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] sig_in,
  output logic [CHANNELS-1:0] sig_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    sync_filt_ch #(
      .SYNC_SIZE (SYNC_SIZE),
      .FILT_LEN  (FILT_LEN),
      .RST_VAL   (RST_VAL[i])
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .sig_in  (sig_in[i]),
      .sig_out (sig_out[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

endmodule

// File: tb/tb_multi_sync_filt.sv
// Directed bench for multi_sync_filt: default build plus a short-filter build.
module tb_multi_sync_filt;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sig_in;
  logic [3:0] sig_out, rise, fall;
  logic [0:0] sig2, out2, rise2, fall2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_sync_filt #(
    .CHANNELS  (4),
    .SYNC_SIZE (2),
    .FILT_LEN  (4),
    .RST_VAL   (4'b1000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig_in  (sig_in),
    .sig_out (sig_out),
    .rise    (rise),
    .fall    (fall)
  );

  multi_sync_filt #(
    .CHANNELS  (1),
    .SYNC_SIZE (3),
    .FILT_LEN  (1),
    .RST_VAL   (1'b0)
  ) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig_in  (sig2),
    .sig_out (out2),
    .rise    (rise2),
    .fall    (fall2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eo,
                         input logic [3:0] er, input logic [3:0] ef);
    chk({tag, ".out"},  32'(sig_out), 32'(eo));
    chk({tag, ".rise"}, 32'(rise),    32'(er));
    chk({tag, ".fall"}, 32'(fall),    32'(ef));
  endtask

  initial begin
    rst_n  = 1'b0;
    sig_in = 4'b0000;
    sig2   = 1'b0;

    // Reset held: input toggles must not leak through
    @(negedge clk);
    sig_in = 4'b0101;
    @(negedge clk);
    chk_all("rst_hold0", 4'b1000, 4'b0000, 4'b0000);
    chk("rst_out2", 32'(out2), 32'd0);
    sig_in = 4'b1010;
    @(negedge clk);
    chk_all("rst_hold1", 4'b1000, 4'b0000, 4'b0000);
    sig_in = 4'b1000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      chk_all("post_rst", 4'b1000, 4'b0000, 4'b0000);
    end

    // Step on ch0: visible after edge 6 with a single rise pulse
    sig_in = 4'b1001;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      chk_all($sformatf("step_e%0d", e),
              (e >= 6) ? 4'b1001 : 4'b1000,
              (e == 6) ? 4'b0001 : 4'b0000,
              4'b0000);
    end

    // Asynchronous reset mid-cycle acts before the next edge
    #1 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 4'b1000, 4'b0000, 4'b0000);
    sig_in = 4'b1000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      chk_all("after_async", 4'b1000, 4'b0000, 4'b0000);
    end

    // Glitch of 3 cycles on ch1 is rejected
    sig_in = 4'b1010;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      chk_all($sformatf("glitch_e%0d", e), 4'b1000, 4'b0000, 4'b0000);
      if (e == 3) sig_in = 4'b1000;
    end
    chk("glitch_cnt", 32'(dut.g_ch[1].u_ch.cnt), 32'd0);

    // 4-cycle pulse on ch1 passes: high 4 cycles, rise then fall
    sig_in = 4'b1010;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      chk_all($sformatf("pulse4_e%0d", e),
              (e >= 6 && e <= 9) ? 4'b1010 : 4'b1000,
              (e == 6)  ? 4'b0010 : 4'b0000,
              (e == 10) ? 4'b0010 : 4'b0000);
      if (e == 4) sig_in = 4'b1000;
    end

    // Simultaneous rise on ch2 and fall on ch3
    sig_in = 4'b0100;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      chk_all($sformatf("simul_e%0d", e),
              (e >= 6) ? 4'b0100 : 4'b1000,
              (e == 6) ? 4'b0100 : 4'b0000,
              (e == 6) ? 4'b1000 : 4'b0000);
    end

    // Reset in the middle of the ch0 count
    sig_in = 4'b0101;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      chk_all($sformatf("midcnt_e%0d", e), 4'b0100, 4'b0000, 4'b0000);
    end
    rst_n = 1'b0;
    #1;
    chk_all("midcnt_rst", 4'b1000, 4'b0000, 4'b0000);
    for (int e = 1; e <= 2; e++) begin
      @(negedge clk);
      chk_all("midcnt_hold", 4'b1000, 4'b0000, 4'b0000);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      chk_all($sformatf("rel_e%0d", e),
              (e >= 6) ? 4'b0101 : 4'b1000,
              (e == 6) ? 4'b0101 : 4'b0000,
              (e == 6) ? 4'b1000 : 4'b0000);
    end

    // SYNC_SIZE=3, FILT_LEN=1: 1-cycle pulse after 4 edges
    sig2 = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      if (e == 1) sig2 = 1'b0;
      chk($sformatf("sw_out_e%0d", e),  32'(out2),  32'(e == 4));
      chk($sformatf("sw_rise_e%0d", e), 32'(rise2), 32'(e == 4));
      chk($sformatf("sw_fall_e%0d", e), 32'(fall2), 32'(e == 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
